// File: rtl/i2c_master_byte_pkg.sv
// Shared definitions for the single-byte I2C master: FSM encodings, bus-level
// constants and the latched command record.
package i2c_master_byte_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_AACK  = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DACK  = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] wr_data;
  } cmd_t;

endpackage

// File: rtl/i2c_master_byte_if.sv
// Command/status handshake between a local controller and i2c_master_byte.
// The controller uses the master modport; the I2C engine uses the slave modport.
interface i2c_master_byte_if;

  logic       start_req;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;

  modport master (
    output start_req, rw, dev_addr, wr_data,
    input  busy, done, ack_err, rd_data
  );

  modport slave (
    input  start_req, rw, dev_addr, wr_data,
    output busy, done, ack_err, rd_data
  );

endinterface

// File: rtl/i2c_master_byte_qphase_gen.sv
// Quarter-phase timebase: counts CLK_DIV clocks per quarter and steps a 2-bit
// phase (0..3) on each wrap. Restarted from phase 0 when a command is accepted.
module i2c_master_byte_qphase_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       q_tick,
  output logic       q_first,
  output logic [1:0] phase
);

  localparam int              CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign q_tick  = (cnt == CNT_LAST);
  assign q_first = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (q_tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain SCL/SDA; reports read byte and ACK status with a 1-cycle done pulse.
module i2c_master_byte
  import i2c_master_byte_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic             clk,
  input  logic             rst,
  i2c_master_byte_if.slave cmd_if,
  inout  wire              SCL,
  inout  wire              SDA
);

  logic [2:0] state;
  logic [2:0] bit_cnt;
  cmd_t       cmd;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       err;
  logic       busy_q, done_q, ack_err_q;
  logic [7:0] rd_data_q;
  logic       scl_oe, sda_oe, scl_oe_nx, sda_oe_nx;
  logic [1:0] sda_sync;
  logic       q_tick, q_first;
  logic [1:0] phase;
  logic       accept, seg_end, sample, sda_in, scl_low;

  assign accept  = (state == ST_IDLE) && cmd_if.start_req && !busy_q;
  assign seg_end = q_tick && (phase == 2'd3);
  assign sample  = q_first && (phase == 2'd2);
  assign sda_in  = sda_sync[1];
  assign scl_low = (phase == 2'd0) || (phase == 2'd3);

  i2c_master_byte_qphase_gen #(.CLK_DIV(CLK_DIV)) u_qphase (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .q_tick  (q_tick),
    .q_first (q_first),
    .phase   (phase)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    scl_oe_nx = 1'b0;
    sda_oe_nx = 1'b0;
    case (state)
      ST_START: sda_oe_nx = phase[1];
      ST_ADDR: begin
        scl_oe_nx = scl_low;
        sda_oe_nx = ~tx_sh[7];
      end
      ST_DATA: begin
        scl_oe_nx = scl_low;
        sda_oe_nx = (cmd.rw == I2C_WRITE) && !tx_sh[7];
      end
      ST_AACK, ST_DACK: scl_oe_nx = scl_low;
      ST_STOP: begin
        scl_oe_nx = (phase == 2'd0);
        sda_oe_nx = (phase != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      cmd       <= '0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      err       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 8'h00;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      sda_sync  <= 2'b11;
    end else begin
      done_q   <= 1'b0;
      scl_oe   <= scl_oe_nx;
      sda_oe   <= sda_oe_nx;
      // SDA is asynchronous to clk (the target drives it); two flops before use.
      sda_sync <= {sda_sync[0], SDA};
      case (state)
        ST_IDLE: if (accept) begin
          cmd    <= '{rw: cmd_if.rw, dev_addr: cmd_if.dev_addr, wr_data: cmd_if.wr_data};
          err    <= 1'b0;
          rx_sh  <= 8'h00;
          busy_q <= 1'b1;
          state  <= ST_START;
        end
        ST_START: if (seg_end) begin
          tx_sh   <= {cmd.dev_addr, cmd.rw};
          bit_cnt <= 3'd0;
          state   <= ST_ADDR;
        end
        ST_ADDR: if (seg_end) begin
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_AACK;
        end
        ST_AACK: begin
          if (sample && sda_in != I2C_ACK) err <= 1'b1;
          if (seg_end) begin
            if (err) begin
              state <= ST_STOP;
            end else begin
              tx_sh <= cmd.wr_data;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sample && cmd.rw == I2C_READ) rx_sh <= {rx_sh[6:0], sda_in};
          if (seg_end) begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_DACK;
          end
        end
        ST_DACK: begin
          // On a read this slot is the master NACK; nothing is sampled.
          if (sample && cmd.rw == I2C_WRITE && sda_in != I2C_ACK) err <= 1'b1;
          if (seg_end) state <= ST_STOP;
        end
        ST_STOP: if (seg_end) begin
          state     <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          ack_err_q <= err;
          if (cmd.rw == I2C_READ && !err) rd_data_q <= rx_sh;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SCL = scl_oe ? 1'b0 : 1'bz;
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign cmd_if.busy    = busy_q;
  assign cmd_if.done    = done_q;
  assign cmd_if.ack_err = ack_err_q;
  assign cmd_if.rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte against a behavioural 7-bit I2C target at
// 0x72 that stores written bytes and echoes the stored byte on reads.
module tb_i2c_master_byte;

  localparam int         CLK_DIV  = 16;
  localparam logic [6:0] SLV_ADDR = 7'h72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  scl, sda;

  pullup (scl);
  pullup (sda);

  logic slv_sda_oe = 1'b0;
  assign sda = slv_sda_oe ? 1'b0 : 1'bz;

  i2c_master_byte_if bus ();

  i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd_if (bus.slave),
    .SCL    (scl),
    .SDA    (sda)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural target plus bus monitor, evaluated away from the master's edge.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WDATA, S_DACK, S_RDATA} slv_st_t;
  slv_st_t    s_st     = S_IDLE;
  logic [7:0] s_sh     = 8'h00;
  logic [7:0] s_datain = 8'h00;
  logic [3:0] s_bits   = 4'd0;
  logic       s_rw     = 1'b0;
  logic       p_scl    = 1'b1;
  logic       p_sda    = 1'b1;
  int         n_start = 0, n_stop = 0, n_high_chg = 0, n_done = 0;

  always @(negedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda !== sda) n_high_chg <= n_high_chg + 1;
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      n_start    <= n_start + 1;
      s_st       <= S_ADDR;
      s_bits     <= 4'd0;
      slv_sda_oe <= 1'b0;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      n_stop     <= n_stop + 1;
      s_st       <= S_IDLE;
      slv_sda_oe <= 1'b0;
    end else if (p_scl === 1'b0 && scl === 1'b1) begin
      if (s_st == S_ADDR || s_st == S_WDATA) s_sh <= {s_sh[6:0], sda};
      s_bits <= s_bits + 4'd1;
    end else if (p_scl === 1'b1 && scl === 1'b0) begin
      case (s_st)
        S_ADDR: if (s_bits == 4'd8) begin
          if (s_sh[7:1] == SLV_ADDR) begin
            slv_sda_oe <= 1'b1;
            s_rw       <= s_sh[0];
            s_st       <= S_AACK;
          end else begin
            s_st <= S_IDLE;
          end
        end
        S_AACK: begin
          s_bits <= 4'd0;
          if (s_rw) begin
            s_st       <= S_RDATA;
            slv_sda_oe <= ~s_datain[7];
          end else begin
            s_st       <= S_WDATA;
            slv_sda_oe <= 1'b0;
          end
        end
        S_WDATA: if (s_bits == 4'd8) begin
          s_datain   <= s_sh;
          slv_sda_oe <= 1'b1;
          s_st       <= S_DACK;
        end
        S_DACK: begin
          slv_sda_oe <= 1'b0;
          s_st       <= S_IDLE;
        end
        S_RDATA: if (s_bits == 4'd8) begin
          slv_sda_oe <= 1'b0;
          s_st       <= S_IDLE;
        end else begin
          slv_sda_oe <= ~s_datain[3'(4'd7 - s_bits)];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (bus.done === 1'b1) n_done <= n_done + 1;

  // One command; lat = cycles from accept edge to done (-1 if none within bound).
  // sda_at_nack samples SDA mid-high of the DACK slot of a full-length transfer.
  task automatic run_xfer(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input int poke_at, output int lat, output logic busy1,
                          output logic sda_at_nack);
    lat         = -1;
    sda_at_nack = 1'bx;
    bus.rw = r; bus.dev_addr = a; bus.wr_data = d; bus.start_req = 1'b1;
    @(posedge clk); #1;
    bus.start_req = 1'b0;
    busy1 = bus.busy;
    for (int c = 1; c <= 2000; c++) begin
      if (c == poke_at) begin
        bus.start_req = 1'b1; bus.rw = ~r; bus.dev_addr = 7'h13; bus.wr_data = 8'hFF;
      end
      @(posedge clk); #1;
      bus.start_req = 1'b0;
      if (c == 18 * 4 * CLK_DIV + 2 * CLK_DIV + CLK_DIV / 2) sda_at_nack = sda;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  int   lat;
  logic busy1, nsda;
  int   dones_before;

  initial begin
    bus.start_req = 1'b0; bus.rw = 1'b0; bus.dev_addr = 7'h00; bus.wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy",    bus.busy,    1'b0);
    check("reset_done",    bus.done,    1'b0);
    check("reset_ack_err", bus.ack_err, 1'b0);
    check("reset_rd_data", bus.rd_data, 8'h00);
    check("reset_scl",     scl,         1'b1);
    check("reset_sda",     sda,         1'b1);
    repeat (5) @(posedge clk);
    #1;

    run_xfer(1'b0, 7'h72, 8'hA5, -1, lat, busy1, nsda);
    check("wr1_busy_after_accept", busy1, 1'b1);
    check("wr1_latency",  lat, 1280);
    check("wr1_ack_err",  bus.ack_err, 1'b0);
    check("wr1_slave_datain", s_datain, 8'hA5);
    check("wr1_busy_end", bus.busy, 1'b0);

    run_xfer(1'b1, 7'h72, 8'h00, -1, lat, busy1, nsda);
    check("rd1_latency", lat, 1280);
    check("rd1_rd_data", bus.rd_data, 8'hA5);
    check("rd1_ack_err", bus.ack_err, 1'b0);
    check("rd1_sda_released_at_nack", nsda, 1'b1);

    run_xfer(1'b0, 7'h13, 8'h3C, -1, lat, busy1, nsda);
    check("nack_latency", lat, 704);
    check("nack_ack_err", bus.ack_err, 1'b1);
    check("nack_slave_datain", s_datain, 8'hA5);
    check("nack_stop_seen", n_stop, 3);
    check("nack_rd_data_kept", bus.rd_data, 8'hA5);

    dones_before = n_done;
    run_xfer(1'b0, 7'h72, 8'h66, 800, lat, busy1, nsda);
    repeat (200) @(posedge clk);
    #1;
    check("poke_latency", lat, 1280);
    check("poke_ack_err", bus.ack_err, 1'b0);
    check("poke_slave_datain", s_datain, 8'h66);
    check("poke_rd_data_kept", bus.rd_data, 8'hA5);
    check("poke_single_done", n_done - dones_before, 1);
    check("poke_idle_after", bus.busy, 1'b0);

    // Reset during the fourth address bit (quarter 0, SCL held low).
    dones_before = n_done;
    bus.rw = 1'b0; bus.dev_addr = 7'h72; bus.wr_data = 8'hC3; bus.start_req = 1'b1;
    @(posedge clk); #1;
    bus.start_req = 1'b0;
    repeat (4 * 4 * CLK_DIV + 3) @(posedge clk);
    #1;
    check("midrst_scl_low_before", scl, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_scl_released", scl, 1'b1);
    check("midrst_sda_released", sda, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_rd_data", bus.rd_data, 8'h00);
    repeat (200) @(posedge clk);
    #1;
    check("midrst_no_done", n_done - dones_before, 0);

    run_xfer(1'b0, 7'h72, 8'h5A, -1, lat, busy1, nsda);
    check("recov_latency", lat, 1280);
    check("recov_ack_err", bus.ack_err, 1'b0);
    check("recov_slave_datain", s_datain, 8'h5A);

    run_xfer(1'b1, 7'h72, 8'h00, -1, lat, busy1, nsda);
    check("rd2_latency", lat, 1280);
    check("rd2_rd_data", bus.rd_data, 8'h5A);
    check("rd2_sda_released_at_nack", nsda, 1'b1);

    check("total_starts", n_start, 7);
    check("total_stops",  n_stop,  6);
    check("total_dones",  n_done,  6);
    check("sda_change_only_start_stop", n_high_chg, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
